if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch sequencer directly downstream of the PC register in the IF stage.
- Samples the current PC, runs a req/ack read on the instruction bus, and holds the fetched word plus its PC in an output register for ID.
- Drives the PC register's enable, so the PC advances or takes a redirect only when this block permits it.

Parameters:
NOP_INST, 32'h00000000, instruction word presented when a fetch faults.
TIMEOUT, 255, max cycles in REQ before a bus error; 0 disables the timeout.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pc  input  32  current PC register value
pc_enable  output  1  PC register update enable (combinational)
flush  input  1  redirect; same cycle as the PC register's is_branch
ibus_req  output  1  bus read request
ibus_addr  output  32  bus address (registered)
ibus_ack  input  1  read data valid, one-cycle pulse
ibus_rdata  input  32  read data
id_ready  input  1  ID accepts the output this cycle
inst_valid  output  1  output register holds an instruction
inst  output  32  fetched instruction
inst_pc  output  32  PC of inst
inst_exc_adel  output  1  misaligned-fetch fault
inst_exc_ibe  output  1  bus-timeout fault

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction) forces these values:
  - state=IDLE.
  - ibus_req=0, ibus_addr=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - Both exception flags 0, timeout counter 0.
  - pc_enable=0.
- ibus_req is 1 exactly when state is REQ or DISCARD.
- Bus rule: once raised, ibus_req and ibus_addr hold until ack. The only exceptions are reset and timeout.
- pc_enable is 1 in the flush cycle, in every state. It is otherwise 1 only where stated below.
- IDLE:
  - flush: stay in IDLE.
  - pc[1:0]!=0: load inst=NOP_INST, inst_pc=pc, adel=1, ibe=0, valid=1; pc_enable=1; go to FULL.
  - Otherwise: ibus_addr<=pc, counter<=0, go to REQ.
- REQ:
  - Counter increments each cycle without ack.
  - flush with ack: drop the data, go to IDLE.
  - flush without ack: go to DISCARD.
  - ack: load inst=ibus_rdata, inst_pc=ibus_addr, both flags 0, valid=1; pc_enable=1; go to FULL.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: load inst=NOP_INST, inst_pc=ibus_addr, ibe=1, valid=1; pc_enable=1; drop ibus_req; go to FULL.
  - Otherwise stay in REQ.
- DISCARD:
  - Keeps requesting at the latched address.
  - ack or timeout: go to IDLE, no output load.
  - flush here only pulses pc_enable.
- FULL:
  - flush: valid<=0, go to IDLE. flush has priority over id_ready.
  - id_ready: valid<=0, go to IDLE.
  - Otherwise hold all outputs.
- Output registers change only at the load and clear points listed above. inst/inst_pc keep stale values when valid=0.
- Latency with a zero-wait bus (ack in the first REQ cycle): inst_valid rises 2 cycles after entering IDLE.
- Throughput is 3 cycles per instruction when id_ready is held high.
- Exactly one pc_enable pulse per delivered instruction or fault, plus one per flush.
- Timeout counter is 8 bits wide when TIMEOUT≤255. It is clog2(TIMEOUT+1) bits otherwise.

Test Plan:
1. Reset release, pc=0x1fc00000, ack in the 1st REQ cycle, rdata=0x3c081234, id_ready=1:
   - ibus_req high one cycle with addr 0x1fc00000.
   - pc_enable pulses in that cycle.
   - Next cycle: inst_valid=1, inst=0x3c081234, inst_pc=0x1fc00000.
   - The following cycle: valid=0.
2. ack delayed 5 cycles, id_ready=0 for 4 cycles afterwards:
   - ibus_req/ibus_addr stable for the whole wait.
   - pc_enable exactly once.
   - Outputs held 4 cycles; IDLE again after id_ready=1.
3. flush in the 2nd REQ cycle, ack 3 cycles later with 0xdeadbeef:
   - pc_enable=1 in the flush cycle.
   - State goes to DISCARD; 0xdeadbeef is never presented.
   - Next fetch uses the new pc value.
4. pc=0x1fc00002:
   - No ibus_req.
   - Output inst=NOP_INST, inst_pc=0x1fc00002, inst_exc_adel=1.
   - One pc_enable pulse.
5. TIMEOUT=4, ack never arrives:
   - ibus_req high exactly 4 cycles, then drops.
   - Output inst_exc_ibe=1, inst_pc=latched address, one pc_enable pulse.
6. rst_n low mid-REQ:
   - ibus_req and inst_valid 0 immediately, with no clock edge needed.
   - After release, a fresh fetch from the current pc.
7. flush and id_ready both high in FULL:
   - valid clears, pc_enable=1, next state IDLE.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch sequencer for the IF stage.
//
// It sits directly after the PC register. In IDLE it samples the current PC
// and runs a req/ack read on the instruction bus. The fetched word and its PC
// are held in an output register until ID consumes them. The block also
// drives the PC register's update enable, so the PC only advances (or takes
// a redirect) when a fetch result or a flush has been accepted here.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc                current PC register value
//   pc_enable         PC register update enable (combinational)
//   flush             redirect, asserted in the same cycle as the PC's is_branch
//   ibus_req          bus read request (high in REQ and DISCARD)
//   ibus_addr         registered bus address, held until ack or timeout
//   ibus_ack          read data valid, one-cycle pulse
//   ibus_rdata        read data
//   id_ready          ID accepts the output register this cycle
//   inst_valid        output register holds an instruction
//   inst, inst_pc     fetched instruction and its PC
//   inst_exc_adel     misaligned-fetch fault
//   inst_exc_ibe      bus-timeout fault
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_enable,
  input  logic        flush,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_exc_adel,
  output logic        inst_exc_ibe
);

  // Counter is 8 bits for the usual case and widens only for long timeouts.
  localparam int CNT_W = (TIMEOUT <= 255) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timeout_cnt;

  logic misaligned;
  logic timeout_hit;
  logic start_req;
  logic cnt_inc;
  logic load_data;
  logic load_adel;
  logic load_ibe;
  logic clr_valid;

  assign misaligned = (pc[1:0] != 2'b00);

  // ">=" rather than "==": a flush on the last REQ cycle carries the counter
  // one past TO_LAST into DISCARD, and that must still count as expired.
  assign timeout_hit = (TIMEOUT != 0) && (timeout_cnt >= TO_LAST);

  // The request is a pure decode of the state, so it cannot glitch with inputs
  // and stays up with a stable address for the whole REQ/DISCARD wait.
  assign ibus_req = (state == REQ) || (state == DISCARD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In REQ a flush beats both ack and timeout. A flush
  // without ack parks in DISCARD, so the outstanding read still completes
  // on the bus but its data is thrown away.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!flush) state_next = misaligned ? FULL : REQ;
      end
      REQ: begin
        if (flush)                         state_next = ibus_ack ? IDLE : DISCARD;
        else if (ibus_ack || timeout_hit)  state_next = FULL;
      end
      DISCARD: begin
        if (ibus_ack || timeout_hit) state_next = IDLE;
      end
      FULL: begin
        if (flush || id_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode. pc_enable pulses once for every delivered
  // instruction or fault, and once for every flush. It is forced low
  // while reset is asserted.
  always_comb begin
    start_req = 1'b0;
    cnt_inc   = 1'b0;
    load_data = 1'b0;
    load_adel = 1'b0;
    load_ibe  = 1'b0;
    clr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (misaligned) load_adel = 1'b1;
          else            start_req = 1'b1;
        end
      end
      REQ: begin
        cnt_inc = !ibus_ack;
        if (!flush) begin
          if (ibus_ack)         load_data = 1'b1;
          else if (timeout_hit) load_ibe  = 1'b1;
        end
      end
      DISCARD: begin
        cnt_inc = !ibus_ack;
      end
      FULL: begin
        clr_valid = flush || id_ready;
      end
      default: ;
    endcase
    pc_enable = rst_n && (flush || load_data || load_adel || load_ibe);
  end

  // Bus address, timeout counter and output register. Each of these changes
  // only at the points decoded above. inst/inst_pc and the fault flags are
  // left stale when valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_addr     <= '0;
      timeout_cnt   <= '0;
      inst_valid    <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
      inst_exc_adel <= 1'b0;
      inst_exc_ibe  <= 1'b0;
    end else begin
      if (start_req) begin
        ibus_addr   <= pc;
        timeout_cnt <= '0;
      end else if (cnt_inc) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end

      if (load_data) begin
        inst          <= ibus_rdata;
        inst_pc       <= ibus_addr;
        inst_exc_adel <= 1'b0;
        inst_exc_ibe  <= 1'b0;
        inst_valid    <= 1'b1;
      end else if (load_adel) begin
        inst          <= NOP_INST;
        inst_pc       <= pc;
        inst_exc_adel <= 1'b1;
        inst_exc_ibe  <= 1'b0;
        inst_valid    <= 1'b1;
      end else if (load_ibe) begin
        inst          <= NOP_INST;
        inst_pc       <= ibus_addr;
        inst_exc_adel <= 1'b0;
        inst_exc_ibe  <= 1'b1;
        inst_valid    <= 1'b1;
      end else if (clr_valid) begin
        inst_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed, self-checking bench for if_fetch.
//
// Two instances share clock and stimulus. dut uses the default timeout and
// covers the normal fetch, wait-state, flush, misaligned and reset cases.
// dut_to uses TIMEOUT=4 with a bus that never acks, and is held in reset
// until the timeout case. Expected fetch results are pushed to a scoreboard
// queue when the stimulus is driven, and popped when the DUT presents them.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_to;
  logic [31:0] pc;
  logic        flush;
  logic        ibus_ack;
  logic        ibus_ack_to;
  logic [31:0] ibus_rdata;
  logic        id_ready;

  logic        pc_enable,     pc_enable_to;
  logic        ibus_req,      ibus_req_to;
  logic [31:0] ibus_addr,     ibus_addr_to;
  logic        inst_valid,    inst_valid_to;
  logic [31:0] inst,          inst_to;
  logic [31:0] inst_pc,       inst_pc_to;
  logic        inst_exc_adel, inst_exc_adel_to;
  logic        inst_exc_ibe,  inst_exc_ibe_to;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
    logic        ibe;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pe_count;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_enable(pc_enable), .flush(flush),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
    .ibus_rdata(ibus_rdata), .id_ready(id_ready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_exc_adel(inst_exc_adel),
    .inst_exc_ibe(inst_exc_ibe)
  );

  if_fetch #(.NOP_INST(32'h0000_0000), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n_to), .pc(pc), .pc_enable(pc_enable_to), .flush(flush),
    .ibus_req(ibus_req_to), .ibus_addr(ibus_addr_to), .ibus_ack(ibus_ack_to),
    .ibus_rdata(ibus_rdata), .id_ready(id_ready), .inst_valid(inst_valid_to),
    .inst(inst_to), .inst_pc(inst_pc_to), .inst_exc_adel(inst_exc_adel_to),
    .inst_exc_ibe(inst_exc_ibe_to)
  );

  // Advance to just after the next rising edge, where registered outputs are settled.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic ack, input logic [31:0] rd,
                               input logic rdy);
    flush      = f;
    ibus_ack   = ack;
    ibus_rdata = rd;
    id_ready   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] i, input logic [31:0] p,
                                 input logic a, input logic b);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    e.adel = a;
    e.ibe  = b;
    return e;
  endfunction

  // Pop the oldest expected result and compare it against the chosen instance.
  task automatic checkFetch(input string tag, input bit use_to);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s: observed output with empty scoreboard expected a queued entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_valid"}, use_to ? inst_valid_to    : inst_valid,    1);
      checkOutput({tag, "_inst"},  use_to ? inst_to          : inst,          e.inst);
      checkOutput({tag, "_pc"},    use_to ? inst_pc_to       : inst_pc,       e.pc);
      checkOutput({tag, "_adel"},  use_to ? inst_exc_adel_to : inst_exc_adel, e.adel);
      checkOutput({tag, "_ibe"},   use_to ? inst_exc_ibe_to  : inst_exc_ibe,  e.ibe);
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    rst_n_to    = 1'b1;
    pc          = 32'h1fc0_0000;
    ibus_ack_to = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    rst_n    = 1'b0;
    rst_n_to = 1'b0;
    #1;

    // Reset values
    checkOutput("rst_req",   ibus_req,      0);
    checkOutput("rst_addr",  ibus_addr,     0);
    checkOutput("rst_valid", inst_valid,    0);
    checkOutput("rst_inst",  inst,          0);
    checkOutput("rst_pc",    inst_pc,       0);
    checkOutput("rst_adel",  inst_exc_adel, 0);
    checkOutput("rst_ibe",   inst_exc_ibe,  0);
    checkOutput("rst_pcen",  pc_enable,     0);
    nextCycle();
    nextCycle();

    // Zero-wait fetch
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h3c08_1234, 1'b1);
    sb.push_back(mkExp(32'h3c08_1234, 32'h1fc0_0000, 1'b0, 1'b0));
    #1;
    checkOutput("t1_req",  ibus_req,  1);
    checkOutput("t1_addr", ibus_addr, 32'h1fc0_0000);
    checkOutput("t1_pcen", pc_enable, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkFetch("t1_out", 1'b0);
    checkOutput("t1_req_off", ibus_req,  0);
    checkOutput("t1_pcen_off", pc_enable, 0);
    nextCycle();
    checkOutput("t1_valid_clr", inst_valid, 0);
    checkOutput("t1_idle_req",  ibus_req,   0);
    pc = 32'h1fc0_0004;

    // Five wait states, then ID stalls for four cycles
    nextCycle();
    pe_count = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      pc = 32'h1fc0_0040 + 32'(i * 4);
      #1;
      checkOutput("t2_req_wait",  ibus_req,  1);
      checkOutput("t2_addr_wait", ibus_addr, 32'h1fc0_0004);
      pe_count += int'(pc_enable);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h8c22_0010, 1'b0);
    sb.push_back(mkExp(32'h8c22_0010, 32'h1fc0_0004, 1'b0, 1'b0));
    #1;
    checkOutput("t2_req_ack", ibus_req, 1);
    pe_count += int'(pc_enable);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, (i == 3));
      #1;
      if (i == 0) checkFetch("t2_out", 1'b0);
      checkOutput("t2_hold_valid", inst_valid, 1);
      checkOutput("t2_hold_inst",  inst,       32'h8c22_0010);
      checkOutput("t2_hold_req",   ibus_req,   0);
      pe_count += int'(pc_enable);
    end
    checkOutput("t2_pcen_once", 32'(pe_count), 1);
    nextCycle();
    checkOutput("t2_idle_valid", inst_valid, 0);
    checkOutput("t2_idle_req",   ibus_req,   0);
    pc = 32'h1fc0_0100;

    // Flush in the second REQ cycle, late ack is discarded
    nextCycle();
    #1;
    checkOutput("t3_r1_req",  ibus_req,  1);
    checkOutput("t3_r1_addr", ibus_addr, 32'h1fc0_0100);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    pc = 32'h1fc0_0200;
    #1;
    checkOutput("t3_flush_pcen", pc_enable, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("t3_d1_req",   ibus_req,   1);
    checkOutput("t3_d1_addr",  ibus_addr,  32'h1fc0_0100);
    checkOutput("t3_d1_pcen",  pc_enable,  0);
    checkOutput("t3_d1_valid", inst_valid, 0);
    nextCycle();
    #1;
    checkOutput("t3_d2_req", ibus_req, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hdead_beef, 1'b1);
    #1;
    checkOutput("t3_d3_req",  ibus_req,  1);
    checkOutput("t3_d3_pcen", pc_enable, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("t3_idle_valid", inst_valid, 0);
    checkOutput("t3_idle_req",   ibus_req,   0);
    nextCycle();
    checkOutput("t3_new_req",  ibus_req,  1);
    checkOutput("t3_new_addr", ibus_addr, 32'h1fc0_0200);
    applyStimulus(1'b0, 1'b1, 32'h2442_0001, 1'b1);
    sb.push_back(mkExp(32'h2442_0001, 32'h1fc0_0200, 1'b0, 1'b0));
    #1;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    pc = 32'h1fc0_0002;
    #1;
    checkFetch("t3_out", 1'b0);

    // Misaligned PC
    nextCycle();
    #1;
    checkOutput("t4_req",  ibus_req,  0);
    checkOutput("t4_pcen", pc_enable, 1);
    sb.push_back(mkExp(32'h0000_0000, 32'h1fc0_0002, 1'b1, 1'b0));
    nextCycle();
    pc = 32'h1fc0_0300;
    #1;
    checkFetch("t4_out", 1'b0);
    checkOutput("t4_full_req",  ibus_req,  0);
    checkOutput("t4_full_pcen", pc_enable, 0);
    nextCycle();
    #1;
    checkOutput("t4_idle_valid", inst_valid, 0);
    checkOutput("t4_idle_pcen",  pc_enable,  0);

    // Asynchronous reset in the middle of REQ
    nextCycle();
    #1;
    checkOutput("t6_req_before", ibus_req,  1);
    checkOutput("t6_addr",       ibus_addr, 32'h1fc0_0300);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_req_async",   ibus_req,      0);
    checkOutput("t6_addr_async",  ibus_addr,     0);
    checkOutput("t6_valid_async", inst_valid,    0);
    checkOutput("t6_pc_async",    inst_pc,       0);
    checkOutput("t6_adel_async",  inst_exc_adel, 0);
    nextCycle();
    checkOutput("t6_req_held", ibus_req, 0);
    rst_n = 1'b1;
    pc    = 32'h1fc0_0400;
    nextCycle();
    checkOutput("t6_fresh_req",  ibus_req,  1);
    checkOutput("t6_fresh_addr", ibus_addr, 32'h1fc0_0400);
    applyStimulus(1'b0, 1'b1, 32'h0000_0021, 1'b1);
    sb.push_back(mkExp(32'h0000_0021, 32'h1fc0_0400, 1'b0, 1'b0));
    #1;
    checkOutput("t6_fresh_pcen", pc_enable, 1);

    // flush and id_ready together in FULL
    nextCycle();
    checkFetch("t7_out", 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    pc = 32'h1fc0_0600;
    #1;
    checkOutput("t7_pcen", pc_enable, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("t7_valid", inst_valid, 0);
    checkOutput("t7_req",   ibus_req,   0);
    checkOutput("t7_pcen_off", pc_enable, 0);
    nextCycle();
    checkOutput("t7_next_req",  ibus_req,  1);
    checkOutput("t7_next_addr", ibus_addr, 32'h1fc0_0600);

    // Bus timeout on the TIMEOUT=4 instance
    rst_n_to = 1'b1;
    pc       = 32'h1fc0_0500;
    sb.push_back(mkExp(32'h0000_0000, 32'h1fc0_0500, 1'b0, 1'b1));
    pe_count = 0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      #1;
      checkOutput("t5_req",  ibus_req_to,  1);
      checkOutput("t5_addr", ibus_addr_to, 32'h1fc0_0500);
      checkOutput("t5_pcen", pc_enable_to, (i == 3));
      pe_count += int'(pc_enable_to);
    end
    nextCycle();
    #1;
    checkOutput("t5_req_drop", ibus_req_to, 0);
    checkFetch("t5_out", 1'b1);
    checkOutput("t5_pcen_off", pc_enable_to, 0);
    checkOutput("t5_pcen_once", 32'(pe_count), 1);
    nextCycle();
    checkOutput("t5_valid_clr", inst_valid_to, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
